// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory busy-wait freeze,
// load-use bubbles, wrong-path squash after redirects, and saturating event counters.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IMEM_BUSY,
  input  logic             DMEM_BUSY,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_USE_RS1,
  input  logic             ID_USE_RS2,
  input  logic [4:0]       EX_RD,
  input  logic             EX_MEM_READ,
  input  logic             EX_REDIRECT,
  output logic             PC_EN,
  output logic             IFID_EN,
  output logic             IDEX_EN,
  output logic             EXMEM_EN,
  output logic             MEMWB_EN,
  output logic             IFID_FLUSH,
  output logic             IDEX_FLUSH,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] REM_INIT = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d, saved_q, saved_d, eff_state;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             busy, lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign busy = IMEM_BUSY | DMEM_BUSY;
  assign lu   = EX_MEM_READ && (EX_RD != 5'd0) &&
                ((ID_USE_RS1 && (ID_RS1 == EX_RD)) || (ID_USE_RS2 && (ID_RS2 == EX_RD)));

  // MEM_WAIT is transparent: once busy drops, the saved context decides this very cycle
  assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

  always_comb begin
    PC_EN      = 1'b1;
    IFID_EN    = 1'b1;
    IDEX_EN    = 1'b1;
    EXMEM_EN   = 1'b1;
    MEMWB_EN   = 1'b1;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    state_d    = state_q;
    saved_d    = saved_q;
    rem_d      = rem_q;
    stall_d    = stall_q;
    flush_d    = flush_q;
    if (!RESET) begin
      {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN} = 5'b0;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
      state_d    = RUN;
      saved_d    = RUN;
      rem_d      = 4'd0;
      stall_d    = '0;
      flush_d    = '0;
    end else if (busy) begin
      {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN} = 5'b0;
      saved_d = eff_state;
      state_d = MEM_WAIT;
      stall_d = sat_inc(stall_q);
    end else begin
      state_d = eff_state;
      if (EX_REDIRECT) begin
        IFID_FLUSH = 1'b1;
        IDEX_FLUSH = 1'b1;
        flush_d    = sat_inc(flush_q);
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          rem_d   = REM_INIT;
        end else begin
          state_d = RUN;
        end
      end else if (eff_state == FLUSH) begin
        // the ID slot holds a squashed instruction, so LU is meaningless here
        IFID_FLUSH = 1'b1;
        rem_d      = rem_q - 4'd1;
        state_d    = (rem_q == 4'd1) ? RUN : FLUSH;
      end else if (lu) begin
        PC_EN      = 1'b0;
        IFID_EN    = 1'b0;
        IDEX_FLUSH = 1'b1;
        stall_d    = sat_inc(stall_q);
      end
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    saved_q <= saved_d;
    rem_q   <= rem_d;
    stall_q <= stall_d;
    flush_q <= flush_d;
  end

  assign STATE     = state_q;
  assign STALL_CNT = stall_q;
  assign FLUSH_CNT = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl: two instances (FLUSH_CYCLES=3/CNT_W=16
// and FLUSH_CYCLES=1/CNT_W=4) share inputs and are tracked by an event-level reference model.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, IMEM_BUSY, DMEM_BUSY, ID_USE_RS1, ID_USE_RS2, EX_MEM_READ, EX_REDIRECT;
  logic [4:0] ID_RS1, ID_RS2, EX_RD;

  logic        pc0, ifid0, idex0, exmem0, memwb0, ifidf0, idexf0;
  logic [1:0]  st0;
  logic [15:0] sc0, fc0;
  logic        pc1, ifid1, idex1, exmem1, memwb1, ifidf1, idexf1;
  logic [1:0]  st1;
  logic [3:0]  sc1, fc1;

  logic [40:0] obs0;
  logic [16:0] obs1;
  assign obs0 = {pc0, ifid0, idex0, exmem0, memwb0, ifidf0, idexf0, st0, sc0, fc0};
  assign obs1 = {pc1, ifid1, idex1, exmem1, memwb1, ifidf1, idexf1, st1, sc1, fc1};

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut0 (
    .CLK(CLK), .RESET(RESET), .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
    .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .EX_REDIRECT(EX_REDIRECT),
    .PC_EN(pc0), .IFID_EN(ifid0), .IDEX_EN(idex0), .EXMEM_EN(exmem0), .MEMWB_EN(memwb0),
    .IFID_FLUSH(ifidf0), .IDEX_FLUSH(idexf0), .STATE(st0), .STALL_CNT(sc0), .FLUSH_CNT(fc0));

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
    .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .EX_REDIRECT(EX_REDIRECT),
    .PC_EN(pc1), .IFID_EN(ifid1), .IDEX_EN(idex1), .EXMEM_EN(exmem1), .MEMWB_EN(memwb1),
    .IFID_FLUSH(ifidf1), .IDEX_FLUSH(idexf1), .STATE(st1), .STALL_CNT(sc1), .FLUSH_CNT(fc1));

  // Reference model: mode 0 run, 1 squashing, 2 waiting on memory (with remembered mode)
  int fcyc[2] = '{3, 1};
  int cmax[2] = '{65535, 15};
  int m_st[2], m_sv[2], m_rem[2], m_stall[2], m_fl[2];
  int n_st[2], n_sv[2], n_rem[2], n_stall[2], n_fl[2];
  logic [6:0] e_ctl[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_sv[k] = 0; m_rem[k] = 0; m_stall[k] = 0; m_fl[k] = 0;
    end
  end

  task automatic model_eval(input int k);
    bit busy, hazard;
    int mode;
    busy   = IMEM_BUSY || DMEM_BUSY;
    hazard = EX_MEM_READ && EX_RD != 0 &&
             ((ID_USE_RS1 && ID_RS1 == EX_RD) || (ID_USE_RS2 && ID_RS2 == EX_RD));
    n_st[k] = m_st[k]; n_sv[k] = m_sv[k]; n_rem[k] = m_rem[k];
    n_stall[k] = m_stall[k]; n_fl[k] = m_fl[k];
    mode = (m_st[k] == 2) ? m_sv[k] : m_st[k];
    if (!RESET) begin
      e_ctl[k] = 7'b00000_11;
      n_st[k] = 0; n_sv[k] = 0; n_rem[k] = 0; n_stall[k] = 0; n_fl[k] = 0;
    end else if (busy) begin
      e_ctl[k] = 7'b00000_00;
      n_sv[k] = mode;
      n_st[k] = 2;
      n_stall[k] = (m_stall[k] < cmax[k]) ? m_stall[k] + 1 : cmax[k];
    end else if (EX_REDIRECT) begin
      e_ctl[k] = 7'b11111_11;
      n_fl[k] = (m_fl[k] < cmax[k]) ? m_fl[k] + 1 : cmax[k];
      if (fcyc[k] > 1) begin
        n_st[k] = 1; n_rem[k] = fcyc[k] - 1;
      end else n_st[k] = 0;
    end else if (mode == 1) begin
      e_ctl[k] = 7'b11111_10;
      n_rem[k] = m_rem[k] - 1;
      n_st[k] = (n_rem[k] == 0) ? 0 : 1;
    end else if (hazard) begin
      e_ctl[k] = 7'b00111_01;
      n_st[k] = 0;
      n_stall[k] = (m_stall[k] < cmax[k]) ? m_stall[k] + 1 : cmax[k];
    end else begin
      e_ctl[k] = 7'b11111_00;
      n_st[k] = 0;
    end
  endtask

  function automatic logic [40:0] exp0();
    return {e_ctl[0], m_st[0][1:0], m_stall[0][15:0], m_fl[0][15:0]};
  endfunction

  function automatic logic [16:0] exp1();
    return {e_ctl[1], m_st[1][1:0], m_stall[1][3:0], m_fl[1][3:0]};
  endfunction

  task automatic drive(input bit rst, ib, db, input int rs1, rs2, input bit u1, u2,
                       input int rd, input bit mr, rdr);
    RESET = rst; IMEM_BUSY = ib; DMEM_BUSY = db;
    ID_RS1 = 5'(rs1); ID_RS2 = 5'(rs2); ID_USE_RS1 = u1; ID_USE_RS2 = u2;
    EX_RD = 5'(rd); EX_MEM_READ = mr; EX_REDIRECT = rdr;
  endtask

  task automatic predict();
    #1;
    model_eval(0);
    model_eval(1);
  endtask

  task automatic tick();
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      m_st[k] = n_st[k]; m_sv[k] = n_sv[k]; m_rem[k] = n_rem[k];
      m_stall[k] = n_stall[k]; m_fl[k] = n_fl[k];
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    predict();
    tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(0, c[0], 1, 5, 5, 1, 1, 5, 1, 1);
      predict();
      checks++;
      if (obs0[40:34] !== e_ctl[0]) begin
        errors++; $display("FAIL reset_ctl0 cyc %0d got %b exp %b", c, obs0[40:34], e_ctl[0]);
      end
      checks++;
      if (obs1[16:10] !== e_ctl[1]) begin
        errors++; $display("FAIL reset_ctl1 cyc %0d got %b exp %b", c, obs1[16:10], e_ctl[1]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    predict();
    checks++;
    if (obs0 !== exp0()) begin errors++; $display("FAIL reset_state0 got %h exp %h", obs0, exp0()); end
    checks++;
    if (obs1 !== exp1()) begin errors++; $display("FAIL reset_state1 got %h exp %h", obs1, exp1()); end
    checks++;
    if ({st0, sc0, fc0} !== 34'd0) begin errors++; $display("FAIL reset_regs got %h exp 0", {st0, sc0, fc0}); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: drive(1, 0, 0, 7, 5, 0, 1, 5, 1, 0);
        1: drive(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        default: drive(1, 0, 0, 9, 3, 1, 0, 9, 1, 0);
      endcase
      predict();
      checks++;
      if (obs0 !== exp0()) begin errors++; $display("FAIL load_use0 cyc %0d got %h exp %h", c, obs0, exp0()); end
      checks++;
      if (obs1 !== exp1()) begin errors++; $display("FAIL load_use1 cyc %0d got %h exp %h", c, obs1, exp1()); end
      tick();
      if (c < 2) begin
        checks++;
        if (sc0 !== 16'd1) begin errors++; $display("FAIL load_use_cnt cyc %0d got %0d exp 1", c, sc0); end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0, 1, 2, 1, 1, 1, 1, c == 0);
      predict();
      checks++;
      if (obs0 !== exp0()) begin errors++; $display("FAIL redirect0 cyc %0d got %h exp %h", c, obs0, exp0()); end
      checks++;
      if (obs1 !== exp1()) begin errors++; $display("FAIL redirect1 cyc %0d got %h exp %h", c, obs1, exp1()); end
      if (c == 3) begin
        checks++;
        if ({st0, fc0} !== {2'd0, 16'd1}) begin
          errors++; $display("FAIL redirect_done got st %0d cnt %0d exp st 0 cnt 1", st0, fc0);
        end
      end
      tick();
    end
  endtask

  task automatic test_busy_freeze();
    int s0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(1, 0, (c >= 2 && c <= 5), 0, 0, 0, 0, 0, 0, c == 0);
      predict();
      if (c == 2) s0 = int'(sc0);
      checks++;
      if (obs0 !== exp0()) begin errors++; $display("FAIL busy_freeze0 cyc %0d got %h exp %h", c, obs0, exp0()); end
      checks++;
      if (obs1 !== exp1()) begin errors++; $display("FAIL busy_freeze1 cyc %0d got %h exp %h", c, obs1, exp1()); end
      if (c == 6) begin
        checks++;
        if ({st0, ifidf0, idexf0, pc0} !== {2'd2, 1'b1, 1'b0, 1'b1} || int'(sc0) != s0 + 4) begin
          errors++; $display("FAIL busy_release got st %0d ff %b%b pc %b stall %0d exp st 2 ff 10 pc 1 stall %0d",
                             st0, ifidf0, idexf0, pc0, sc0, s0 + 4);
        end
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1, c == 0, 0, 4, 0, 1, 0, 4, c < 2, c < 2);
      predict();
      checks++;
      if (obs0 !== exp0()) begin errors++; $display("FAIL simultaneous0 cyc %0d got %h exp %h", c, obs0, exp0()); end
      checks++;
      if (obs1 !== exp1()) begin errors++; $display("FAIL simultaneous1 cyc %0d got %h exp %h", c, obs1, exp1()); end
      tick();
      if (c == 1) begin
        checks++;
        if ({fc0, sc0} !== {16'd1, 16'd1}) begin
          errors++; $display("FAIL simultaneous_cnt got flush %0d stall %0d exp 1 1", fc0, sc0);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      predict();
      checks++;
      if (obs1 !== exp1()) begin errors++; $display("FAIL saturation1 cyc %0d got %h exp %h", c, obs1, exp1()); end
      tick();
    end
    checks++;
    if ({sc1, sc0} !== {4'd15, 16'd20}) begin
      errors++; $display("FAIL saturation_cnt got %0d/%0d exp 15/20", sc1, sc0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(49, 0) != 0, $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0,
            $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(1, 0),
            $urandom_range(3, 0), $urandom_range(2, 0) == 0, $urandom_range(6, 0) == 0);
      predict();
      checks++;
      if (obs0 !== exp0()) begin errors++; $display("FAIL random0 cyc %0d got %h exp %h", c, obs0, exp0()); end
      checks++;
      if (obs1 !== exp1()) begin errors++; $display("FAIL random1 cyc %0d got %h exp %h", c, obs1, exp1()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_busy_freeze();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It watches the ID and EX stages and the instruction/data memory busy-wait lines, and drives the per-register enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers global freeze on memory busy-wait, one-cycle load-use bubbles, and multi-cycle wrong-path squash after a taken branch or jump. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- FLUSH_CYCLES, 1: IF/ID squash cycles per redirect, counting the redirect cycle itself; legal range 1..15.
- CNT_W, 16: width of the performance counters.

Ports:
- CLK  in  1: clock; all state updates on the rising edge.
- RESET  in  1: synchronous, active-low reset.
- IMEM_BUSY  in  1: instruction memory busy-wait.
- DMEM_BUSY  in  1: data memory busy-wait.
- ID_RS1, ID_RS2  in  5 each: source register addresses of the instruction in ID.
- ID_USE_RS1, ID_USE_RS2  in  1 each: ID instruction actually reads rs1 / rs2.
- EX_RD  in  5: destination register of the instruction in EX.
- EX_MEM_READ  in  1: EX instruction is a load (OR of the 3-bit MEM_READ field).
- EX_REDIRECT  in  1: taken branch or jump resolved in EX this cycle.
- PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN  out  1 each: register load enables.
- IFID_FLUSH, IDEX_FLUSH  out  1 each: load a bubble (all-zero controls) instead of the inputs.
- STATE  out  2: FSM state; 0 RUN, 1 FLUSH, 2 MEM_WAIT.
- STALL_CNT  out  CNT_W: cycles with any freeze or bubble, saturating.
- FLUSH_CNT  out  CNT_W: redirect events taken, saturating.

## Operation
- BUSY = IMEM_BUSY | DMEM_BUSY.
- LU (load-use) = EX_MEM_READ & (EX_RD != 0) & ((ID_USE_RS1 & ID_RS1 == EX_RD) | (ID_USE_RS2 & ID_RS2 == EX_RD)).
- Outputs are combinational from state and inputs. Priority is: RESET low, then BUSY, then EX_REDIRECT, then FLUSH-state squash, then LU, then normal.
- RESET low: all enables 0; IFID_FLUSH and IDEX_FLUSH 1. Next state RUN, squash count 0, both counters 0.
- BUSY, any state: all five enables 0, both flushes 0 (global freeze).
  - Save the current state and the remaining squash count.
  - Next state MEM_WAIT; stays there while BUSY.
- MEM_WAIT with BUSY low: outputs and transitions are evaluated exactly as in the saved state that same cycle; no dead cycle.
- EX_REDIRECT (not BUSY), any state:
  - PC_EN = 1 (loads the target); all enables 1; IFID_FLUSH = 1; IDEX_FLUSH = 1.
  - FLUSH_CNT += 1.
  - If FLUSH_CYCLES > 1: next state FLUSH, remaining count = FLUSH_CYCLES-1. Otherwise next state RUN.
- FLUSH (not BUSY, no new redirect):
  - All enables 1; IFID_FLUSH = 1; IDEX_FLUSH = 0; LU ignored (the ID slot is a bubble).
  - Remaining count decrements; on reaching 0, next state RUN.
  - A new EX_REDIRECT in FLUSH restarts the count.
- RUN with LU:
  - PC_EN = 0 and IFID_EN = 0 (hold fetch/decode).
  - IDEX_EN = 1 with IDEX_FLUSH = 1 (bubble into EX).
  - EXMEM_EN = 1, MEMWB_EN = 1.
  - No state change. The next cycle EX holds a bubble, so LU self-clears.
- RUN otherwise: all enables 1, flushes 0.
- STALL_CNT increments in every non-reset cycle with BUSY, or with LU acting in RUN. FLUSH_CNT increments per redirect cycle. Both saturate at 2^CNT_W-1, with no wrap.
- A redirect held during a freeze is not counted until the cycle it is acted on.

## Timing
- Zero-latency control: enables and flushes reflect inputs in the same cycle. Pipeline registers sample them at the next rising edge.
- State, squash count and counters update on the rising edge only.
- Reset: applied at the first rising edge with RESET = 0. Output forcing is combinational while RESET = 0.
- Reset mid-FLUSH or mid-MEM_WAIT abandons the saved context. Return is to RUN with counters cleared.
- Simultaneous events:
  - BUSY + EX_REDIRECT: freeze wins. EX is held, so the redirect is re-presented and acted on in the first non-busy cycle.
  - EX_REDIRECT + LU: redirect wins; no bubble; STALL_CNT not incremented.
  - BUSY + LU: freeze only; STALL_CNT increments once.
- With FLUSH_CYCLES = 1, the FLUSH state is never entered.

## Test plan
- Reset: hold RESET = 0 for 2 cycles -> all enables 0, both flushes 1, STATE = 0, STALL_CNT = FLUSH_CNT = 0.
- Load-use: EX_MEM_READ = 1, EX_RD = 5, ID_RS2 = 5, ID_USE_RS2 = 1 for one cycle -> PC_EN = IFID_EN = 0, IDEX_FLUSH = 1, STALL_CNT = 1.
  - Same with EX_RD = 0 -> no stall.
- Redirect, FLUSH_CYCLES = 3: pulse EX_REDIRECT ->
  - Redirect cycle: IFID_FLUSH and IDEX_FLUSH = 1.
  - Next 2 cycles: IFID_FLUSH = 1 only, STATE = 1.
  - Then STATE = 0; FLUSH_CNT = 1.
- Busy freeze: DMEM_BUSY = 1 for 4 cycles during FLUSH, with 1 squash cycle remaining ->
  - All enables 0 and STATE = 2 for 4 cycles; STALL_CNT += 4.
  - On release, one IFID_FLUSH cycle, then RUN.
- Simultaneous: BUSY + EX_REDIRECT + LU together, then BUSY drops with EX_REDIRECT still high ->
  - First cycle: freeze only.
  - Next cycle: redirect with no bubble; FLUSH_CNT = 1.
- Saturation, CNT_W = 4: hold IMEM_BUSY for 20 cycles -> STALL_CNT stops at 15.
